// File: rtl/sdram_rd32_responder_if.sv
// Bundle between the ROM-read initiator, the 32-bit responder and the SDRAM controller's 16-bit word port.
// Handshakes: sdr_req is a one-cycle request pulse answered by exactly one one-cycle sdr_rdy pulse;
// mem_req is a level held until the one-cycle mem_ack, and mem_q is valid only while mem_ack is high.
interface sdram_rd32_responder_if;
  logic [24:0] sdr_addr;
  logic        sdr_req;
  logic [31:0] sdr_data;
  logic        sdr_rdy;
  logic        cache_flush;
  logic [24:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_q;

  modport master (
    output sdr_addr, sdr_req, cache_flush, mem_ack, mem_q,
    input  sdr_data, sdr_rdy, mem_addr, mem_req
  );

  modport slave (
    input  sdr_addr, sdr_req, cache_flush, mem_ack, mem_q,
    output sdr_data, sdr_rdy, mem_addr, mem_req
  );
endinterface

// File: rtl/sdram_rd32_responder.sv
// Returns 32-bit ROM words built from two 16-bit SDRAM reads, with a one-word
// last-read cache and a one-entry slot for a request arriving mid-read.
module sdram_rd32_responder #(
    parameter bit CACHE_EN  = 1'b1,
    parameter bit WORD_SWAP = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    sdram_rd32_responder_if.slave        bus,
    output logic [2:0]                   dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        GAP   = 3'd2,
        RD_HI = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [22:0] wa_q, wa_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        mreq_q, mreq_d;
    logic [24:0] maddr_q, maddr_d;
    logic [22:0] tag_q, tag_d;
    logic [31:0] cdata_q, cdata_d;
    logic        cvalid_q, cvalid_d;
    logic        pend_q, pend_d;
    logic [22:0] paddr_q, paddr_d;
    logic        nofill_q, nofill_d;

    logic [22:0] req_wa;
    logic        take_req;
    logic        hit;
    logic        unused_addr_bits;

    // Byte-lane bits of the request address carry no information for word reads.
    assign unused_addr_bits = ^bus.sdr_addr[1:0];

    assign req_wa   = bus.sdr_req ? bus.sdr_addr[24:2] : paddr_q;
    assign take_req = bus.sdr_req | pend_q;
    assign hit      = CACHE_EN && cvalid_q && (tag_q == req_wa) && !bus.cache_flush;

    always_comb begin
        state_d  = state_q;
        wa_d     = wa_q;
        lo_d     = lo_q;
        data_d   = data_q;
        rdy_d    = 1'b0;
        mreq_d   = mreq_q;
        maddr_d  = maddr_q;
        tag_d    = tag_q;
        cdata_d  = cdata_q;
        cvalid_d = cvalid_q;
        pend_d   = pend_q;
        paddr_d  = paddr_q;
        nofill_d = nofill_q;

        case (state_q)
            IDLE: begin
                if (take_req) begin
                    // A live sdr_req wins; the slot is only consumed when it supplied the request.
                    if (!bus.sdr_req) pend_d = 1'b0;
                    if (hit) begin
                        data_d = cdata_q;
                        rdy_d  = 1'b1;
                    end else begin
                        wa_d    = req_wa;
                        maddr_d = {req_wa, 2'b00};
                        mreq_d  = 1'b1;
                        state_d = RD_LO;
                    end
                end
            end
            RD_LO: begin
                if (bus.mem_ack) begin
                    lo_d    = bus.mem_q;
                    mreq_d  = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                maddr_d = {wa_q, 2'b10};
                mreq_d  = 1'b1;
                state_d = RD_HI;
            end
            RD_HI: begin
                if (bus.mem_ack) begin
                    mreq_d  = 1'b0;
                    data_d  = WORD_SWAP ? {lo_q, bus.mem_q} : {bus.mem_q, lo_q};
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (CACHE_EN && !nofill_q) begin
                    tag_d    = wa_q;
                    cdata_d  = data_q;
                    cvalid_d = 1'b1;
                end
                nofill_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && bus.sdr_req) begin
            pend_d  = 1'b1;
            paddr_d = bus.sdr_addr[24:2];
        end

        // A flush seen while a fill is in flight must keep that stale word out of the cache.
        if (bus.cache_flush) begin
            cvalid_d = 1'b0;
            if (state_q == RD_LO || state_q == GAP || state_q == RD_HI) nofill_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wa_q     <= '0;
            lo_q     <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
            mreq_q   <= 1'b0;
            maddr_q  <= '0;
            tag_q    <= '0;
            cdata_q  <= '0;
            cvalid_q <= 1'b0;
            pend_q   <= 1'b0;
            paddr_q  <= '0;
            nofill_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wa_q     <= wa_d;
            lo_q     <= lo_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            mreq_q   <= mreq_d;
            maddr_q  <= maddr_d;
            tag_q    <= tag_d;
            cdata_q  <= cdata_d;
            cvalid_q <= cvalid_d;
            pend_q   <= pend_d;
            paddr_q  <= paddr_d;
            nofill_q <= nofill_d;
        end
    end

    assign bus.sdr_data = data_q;
    assign bus.sdr_rdy  = rdy_q;
    assign bus.mem_req  = mreq_q;
    assign bus.mem_addr = maddr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sdram_rd32_responder.sv
// Bench for sdram_rd32_responder: instance 0 is cached/unswapped, instance 1 is uncached/swapped.
// A word-addressed memory model supplies read data and a request-level model predicts every sdr_rdy.
module tb_sdram_rd32_responder;

    typedef struct {
        logic [31:0] data;
        logic [22:0] tag;
        bit          miss;
        bit          nofill;
        int          issue_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;

    logic [24:0] sdr_addr_v    [2];
    logic        sdr_req_v     [2];
    logic        cache_flush_v [2];
    logic        mem_ack_v     [2];
    logic [15:0] mem_q_v       [2];
    logic [31:0] sdr_data_o    [2];
    logic        sdr_rdy_o     [2];
    logic [24:0] mem_addr_o    [2];
    logic        mem_req_o     [2];
    logic [2:0]  dbg_o         [2];

    int checks   = 0;
    int failures = 0;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    logic [24:0] mem_log[$];
    bit          m_valid       [2];
    logic [22:0] m_tag         [2];
    logic [31:0] last_data     [2];
    int          n_acks        [2];
    int          exp_acks      [2];
    int          last_ack_edge [2];
    int          ack_dly       [2];
    bit          ack_en        [2];
    bit          force_ack     [2];

    sdram_rd32_responder_if bus0();
    sdram_rd32_responder_if bus1();

    assign bus0.sdr_addr    = sdr_addr_v[0];
    assign bus0.sdr_req     = sdr_req_v[0];
    assign bus0.cache_flush = cache_flush_v[0];
    assign bus0.mem_ack     = mem_ack_v[0];
    assign bus0.mem_q       = mem_q_v[0];
    assign sdr_data_o[0]    = bus0.sdr_data;
    assign sdr_rdy_o[0]     = bus0.sdr_rdy;
    assign mem_addr_o[0]    = bus0.mem_addr;
    assign mem_req_o[0]     = bus0.mem_req;

    assign bus1.sdr_addr    = sdr_addr_v[1];
    assign bus1.sdr_req     = sdr_req_v[1];
    assign bus1.cache_flush = cache_flush_v[1];
    assign bus1.mem_ack     = mem_ack_v[1];
    assign bus1.mem_q       = mem_q_v[1];
    assign sdr_data_o[1]    = bus1.sdr_data;
    assign sdr_rdy_o[1]     = bus1.sdr_rdy;
    assign mem_addr_o[1]    = bus1.mem_addr;
    assign mem_req_o[1]     = bus1.mem_req;

    sdram_rd32_responder #(.CACHE_EN(1'b1), .WORD_SWAP(1'b0)) dut0 (
        .clk(clk), .reset(rst), .bus(bus0), .dbg_state(dbg_o[0])
    );

    sdram_rd32_responder #(.CACHE_EN(1'b0), .WORD_SWAP(1'b1)) dut1 (
        .clk(clk), .reset(rst), .bus(bus1), .dbg_state(dbg_o[1])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- models ----------------
    function automatic logic [15:0] mem_word(input logic [24:0] a);
        if (a == 25'h000104) return 16'h1111;
        if (a == 25'h000106) return 16'h2222;
        return a[16:1] ^ 16'hC3A5;
    endfunction

    function automatic logic [31:0] exp_word(input logic [22:0] wa, input bit swap);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = mem_word({wa, 2'b00});
        hi = mem_word({wa, 2'b10});
        return swap ? {lo, hi} : {hi, lo};
    endfunction

    function automatic int q_size(input int idx);
        return (idx == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic model_flush(input int idx);
        m_valid[idx] = 1'b0;
        if (idx == 0) foreach (exp_q0[i]) exp_q0[i].nofill = 1'b1;
        else          foreach (exp_q1[i]) exp_q1[i].nofill = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input int idx, input logic [24:0] a);
        exp_t e;
        e.tag       = a[24:2];
        e.data      = exp_word(a[24:2], idx == 1);
        e.miss      = !(idx == 0 && m_valid[idx] && m_tag[idx] == a[24:2] && !cache_flush_v[idx]);
        e.nofill    = 1'b0;
        e.issue_cyc = cyc + 1;
        if (e.miss) exp_acks[idx] += 2;
        if (idx == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
        sdr_addr_v[idx] = a;
        sdr_req_v[idx]  = 1'b1;
        step();
        sdr_req_v[idx]  = 1'b0;
    endtask

    task automatic flush_pulse(input int idx, input int n);
        cache_flush_v[idx] = 1'b1;
        model_flush(idx);
        repeat (n) step();
        cache_flush_v[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx);
        int t = 0;
        while (q_size(idx) != 0 && t < 400) begin
            step();
            t++;
        end
        chk("done_timeout", q_size(idx), 0);
        repeat (2) step();
    endtask

    task automatic wait_acks(input int idx, input int target);
        int t = 0;
        while (n_acks[idx] < target && t < 200) begin
            step();
            t++;
        end
        chk("ack_timeout", (n_acks[idx] >= target), 1'b1);
    endtask

    // SDRAM controller stand-in: acks a held mem_req after ack_dly cycles.
    task automatic responder(input int idx);
        int cnt   = 0;
        bit acked = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_v[idx] = 1'b0;
            if (force_ack[idx]) begin
                mem_ack_v[idx] = 1'b1;
                mem_q_v[idx]   = 16'hDEAD;
                force_ack[idx] = 1'b0;
            end else if (!mem_req_o[idx] || rst) begin
                cnt   = 0;
                acked = 1'b0;
            end else if (ack_en[idx] && !acked) begin
                if (cnt >= ack_dly[idx]) begin
                    chk("mem_addr_bit0", mem_addr_o[idx][0], 1'b0);
                    mem_ack_v[idx]     = 1'b1;
                    mem_q_v[idx]       = mem_word(mem_addr_o[idx]);
                    acked              = 1'b1;
                    n_acks[idx]        = n_acks[idx] + 1;
                    last_ack_edge[idx] = cyc + 1;
                    if (idx == 0) mem_log.push_back(mem_addr_o[idx]);
                end else begin
                    cnt++;
                end
            end
        end
    endtask

    // ---------------- scoreboard compare ----------------
    task automatic compare_proc(input int idx);
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_data[idx] = '0;
                continue;
            end
            if (sdr_rdy_o[idx]) begin
                if (q_size(idx) == 0) begin
                    chk("unexpected_rdy", sdr_rdy_o[idx], 1'b0);
                end else begin
                    if (idx == 0) e = exp_q0.pop_front();
                    else          e = exp_q1.pop_front();
                    chk("rdy_data", sdr_data_o[idx], e.data);
                    if (e.miss) chk("miss_latency", cyc, last_ack_edge[idx]);
                    else        chk("hit_latency", cyc, e.issue_cyc);
                    if (e.miss && !e.nofill && idx == 0) begin
                        m_valid[idx] = 1'b1;
                        m_tag[idx]   = e.tag;
                    end
                    last_data[idx] = e.data;
                end
            end else begin
                chk("data_hold", sdr_data_o[idx], last_data[idx]);
            end
        end
    endtask

    initial responder(0);
    initial responder(1);
    initial compare_proc(0);
    initial compare_proc(1);

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sdr_addr_v[i] = '0;  sdr_req_v[i] = 1'b0;  cache_flush_v[i] = 1'b0;
            mem_ack_v[i]  = 1'b0; mem_q_v[i]  = '0;    m_valid[i] = 1'b0;
            m_tag[i]      = '0;  last_data[i] = '0;    n_acks[i] = 0;
            exp_acks[i]   = 0;   last_ack_edge[i] = 0; ack_en[i] = 1'b1;
            force_ack[i]  = 1'b0;
        end
        ack_dly[0] = 1;
        ack_dly[1] = 2;
        repeat (3) step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 2; i++) begin
            chk("reset_rdy",   sdr_rdy_o[i],  1'b0);
            chk("reset_data",  sdr_data_o[i], 32'h0);
            chk("reset_mreq",  mem_req_o[i],  1'b0);
            chk("reset_maddr", mem_addr_o[i], 25'h0);
        end

        // Miss then hit on the same word.
        issue(0, 25'h000104);
        wait_done(0);
        chk("t1_data_literal", sdr_data_o[0], 32'h22221111);
        chk("t1_log_size", mem_log.size(), 2);
        if (mem_log.size() == 2) begin
            chk("t1_lo_addr", mem_log[0], 25'h000104);
            chk("t1_hi_addr", mem_log[1], 25'h000106);
        end
        issue(0, 25'h000106);
        for (int k = 0; k < 3; k++) begin
            chk("hit_no_mreq", mem_req_o[0], 1'b0);
            step();
        end
        wait_done(0);
        chk("t1_acks_literal", n_acks[0], 2);

        // Request arriving during RD_HI lands in the pending slot.
        base = n_acks[0];
        issue(0, 25'h000000);
        wait_acks(0, base + 1);
        repeat (2) step();
        issue(0, 25'h000010);
        wait_done(0);
        chk("b2b_acks", n_acks[0], exp_acks[0]);

        // One-cycle flush, then flush held across a fill.
        issue(0, 25'h000020);
        wait_done(0);
        flush_pulse(0, 1);
        issue(0, 25'h000020);
        wait_done(0);
        chk("flush_pulse_acks", n_acks[0], exp_acks[0]);
        issue(0, 25'h000030);
        cache_flush_v[0] = 1'b1;
        model_flush(0);
        wait_done(0);
        cache_flush_v[0] = 1'b0;
        step();
        issue(0, 25'h000030);
        wait_done(0);
        chk("flush_held_acks", n_acks[0], exp_acks[0]);
        chk("flush_acks_literal", n_acks[0], 14);

        // Reset while waiting for the high-half ack, then a stray late ack.
        base = n_acks[0];
        issue(0, 25'h000050);
        wait_acks(0, base + 1);
        ack_en[0] = 1'b0;
        repeat (3) step();
        chk("rst_mid_mreq_high", mem_req_o[0], 1'b1);
        rst = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        exp_acks[0] -= 1;
        step();
        rst = 1'b0;
        force_ack[0] = 1'b1;
        repeat (5) step();
        chk("rst_mid_mreq", mem_req_o[0], 1'b0);
        chk("rst_mid_data", sdr_data_o[0], 32'h0);
        chk("rst_mid_rdy",  sdr_rdy_o[0],  1'b0);
        ack_en[0] = 1'b1;
        issue(0, 25'h000050);
        wait_done(0);
        chk("rst_recover_acks", n_acks[0], exp_acks[0]);

        // Uncached, swapped instance.
        issue(1, 25'h000104);
        wait_done(1);
        chk("swap_literal", sdr_data_o[1], 32'h11112222);
        issue(1, 25'h000106);
        wait_done(1);
        issue(1, 25'h000040);
        wait_done(1);
        issue(1, 25'h000040);
        wait_done(1);
        chk("nocache_acks", n_acks[1], exp_acks[1]);
        chk("nocache_acks_literal", n_acks[1], 8);

        chk("final_q0_empty", exp_q0.size(), 0);
        chk("final_q1_empty", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
